// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue slice.
// The entry and counter typedefs are sized from the default configuration below.
package fetch_pkg;

  localparam int FETCH_AW    = 8;
  localparam int FETCH_DW    = 32;
  localparam int FETCH_DEPTH = 4;
  localparam int PC_INCR     = 4;
  localparam int CNT_W       = $clog2(FETCH_DEPTH) + 1;

  typedef logic [CNT_W-1:0] fetch_cnt_t;

  typedef struct packed {
    logic [FETCH_AW-1:0] pc;
    logic [FETCH_DW-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and empty/full/count status; read data is the
// current head (show-ahead). DEPTH must be a power of two.
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign rdata   = mem[rd_ptr[PW-1:0]];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= wdata;
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front end: owns the PC, issues in-order imem requests, queues {pc, instr}
// for decode and drops stale responses after a redirect. FETCH_BYPASS_EN adds a 0-cycle empty-queue path.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = FETCH_AW,
  parameter int                       DATA_WIDTH    = FETCH_DW,
  parameter int                       DEPTH         = FETCH_DEPTH,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [ADDRESS_WIDTH-1:0] imem_req_addr,
  input  logic                     imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]    imem_rsp_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDRESS_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0]    out_instr
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDRESS_WIDTH-1:0] fetch_pc;
  fetch_cnt_t               live_cnt;
  fetch_cnt_t               drop_cnt;
  fetch_cnt_t               q_count;
  fetch_cnt_t               pend_count;
  logic [CW+1:0]            in_use;
  logic                     q_empty;
  logic                     q_full;
  logic                     pend_empty;
  logic                     pend_full;
  fetch_entry_t             q_wdata;
  fetch_entry_t             q_rdata;
  logic [ADDRESS_WIDTH-1:0] pend_pc;
  logic                     req_fire;
  logic                     rsp_live;
  logic                     rsp_drop;
  logic                     q_push;
  logic                     q_pop;
  logic                     bypass_show;
  logic                     bypass_take;

  // Every slot is accounted for: requests in flight, stale ones to drop, and buffered words.
  assign in_use         = (CW+2)'(live_cnt) + (CW+2)'(drop_cnt) + (CW+2)'(q_count);
  assign imem_req_valid = rst_n && !redirect_valid && (in_use < (CW+2)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_live = imem_rsp_valid && (drop_cnt == '0);
  assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);

`ifdef FETCH_BYPASS_EN
  assign bypass_show = q_empty && rsp_live && !redirect_valid;
`else
  assign bypass_show = 1'b0;
`endif
  assign bypass_take = bypass_show && out_ready;

  assign q_wdata = '{pc: pend_pc, instr: imem_rsp_data};
  assign q_push  = rsp_live && !redirect_valid && !bypass_take;
  assign q_pop   = !q_empty && out_ready && !redirect_valid;

  always_comb begin
    out_valid = !q_empty;
    out_pc    = q_empty ? '0 : q_rdata.pc;
    out_instr = q_empty ? '0 : q_rdata.instr;
    if (bypass_show) begin
      out_valid = 1'b1;
      out_pc    = pend_pc;
      out_instr = imem_rsp_data;
    end
  end

  // A redirect discards whatever is still owed by memory, minus the response landing now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      live_cnt <= '0;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
      live_cnt <= '0;
      drop_cnt <= drop_cnt + live_cnt - fetch_cnt_t'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + ADDRESS_WIDTH'(PC_INCR);
      live_cnt <= live_cnt + fetch_cnt_t'(req_fire) - fetch_cnt_t'(rsp_live);
      drop_cnt <= drop_cnt - fetch_cnt_t'(rsp_drop);
    end
  end

  fetch_fifo #(
    .WIDTH (ADDRESS_WIDTH),
    .DEPTH (DEPTH)
  ) u_pending (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (req_fire),
    .wdata (fetch_pc),
    .pop   (rsp_live),
    .rdata (pend_pc),
    .empty (pend_empty),
    .full  (pend_full),
    .count (pend_count)
  );

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (q_push),
    .wdata (q_wdata),
    .pop   (q_pop),
    .rdata (q_rdata),
    .empty (q_empty),
    .full  (q_full),
    .count (q_count)
  );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed table-driven bench for instr_fetch_queue; each row is one clock cycle
// acting as instruction memory and decode, with hand-computed expected outputs.
module tb_instr_fetch_queue;

`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [7:0]  imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_pc;
  logic [31:0] out_instr;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        rv;
    logic [7:0]  rpc;
    logic        rqr;
    logic        rsv;
    logic [31:0] rsd;
    logic        ordy;
    logic        qv;
    logic [7:0]  qa;
    logic        ov;
    logic [7:0]  opc;
    logic [31:0] oin;
  } vec_t;

  vec_t vecs[$];

  instr_fetch_queue #(
    .ADDRESS_WIDTH (8),
    .DATA_WIDTH    (32),
    .DEPTH         (4),
    .RESET_PC      (8'h00)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dat(input logic [7:0] a);
    return {24'hA00000, a};
  endfunction

  task automatic add_vec(input logic rv, input logic [7:0] rpc, input logic rqr,
                         input logic rsv, input logic [31:0] rsd, input logic ordy,
                         input logic qv, input logic [7:0] qa, input logic ov,
                         input logic [7:0] opc, input logic [31:0] oin);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.rqr = rqr; v.rsv = rsv; v.rsd = rsd; v.ordy = ordy;
    v.qv = qv; v.qa = qa; v.ov = ov; v.opc = opc; v.oin = oin;
    vecs.push_back(v);
  endtask

  task automatic apply_stimulus(input vec_t v);
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    imem_req_ready = v.rqr;
    imem_rsp_valid = v.rsv;
    imem_rsp_data  = v.rsd;
    out_ready      = v.ordy;
  endtask

  task automatic check_output(input string name, input logic qv, input logic [7:0] qa,
                              input logic ov, input logic [7:0] opc, input logic [31:0] oin);
    vectors++;
    if (imem_req_valid !== qv || imem_req_addr !== qa || out_valid !== ov ||
        out_pc !== opc || out_instr !== oin) begin
      miscompares++;
      $display("[TB] FAIL %s: got req_valid=%0b addr=%h out_valid=%0b pc=%h instr=%h, expected req_valid=%0b addr=%h out_valid=%0b pc=%h instr=%h",
               name, imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
               qv, qa, ov, opc, oin);
    end
  endtask

  // The queue must never be pushed while full.
  always @(negedge clk) begin
    if (rst_n && dut.q_push && dut.q_full) begin
      miscompares++;
      $display("[TB] FAIL queue_overflow: got push with full queue, expected no push");
    end
  end

  initial begin
    //      rv  rpc    rqr rsv rsd            ordy | qv  qa     ov   opc               oin
    // issue stalls after four requests with no responses
    add_vec(0, 8'h00, 1, 0, 32'h0,        0,   1, 8'h00, 0,   8'h00,            32'h0);
    add_vec(0, 8'h00, 1, 0, 32'h0,        0,   1, 8'h04, 0,   8'h00,            32'h0);
    add_vec(0, 8'h00, 1, 0, 32'h0,        0,   1, 8'h08, 0,   8'h00,            32'h0);
    add_vec(0, 8'h00, 1, 0, 32'h0,        0,   1, 8'h0C, 0,   8'h00,            32'h0);
    add_vec(0, 8'h00, 1, 0, 32'h0,        0,   0, 8'h10, 0,   8'h00,            32'h0);
    add_vec(0, 8'h00, 1, 0, 32'h0,        0,   0, 8'h10, 0,   8'h00,            32'h0);
    // backpressure: four responses buffered
    add_vec(0, 8'h00, 1, 1, dat(8'h00),   0,   0, 8'h10, BYP, 8'h00,            BYP ? dat(8'h00) : 32'h0);
    add_vec(0, 8'h00, 1, 1, dat(8'h04),   0,   0, 8'h10, 1,   8'h00,            dat(8'h00));
    add_vec(0, 8'h00, 1, 1, dat(8'h08),   0,   0, 8'h10, 1,   8'h00,            dat(8'h00));
    add_vec(0, 8'h00, 1, 1, dat(8'h0C),   0,   0, 8'h10, 1,   8'h00,            dat(8'h00));
    add_vec(0, 8'h00, 1, 0, 32'h0,        0,   0, 8'h10, 1,   8'h00,            dat(8'h00));
    // drain in order, refilling as slots free up
    add_vec(0, 8'h00, 1, 0, 32'h0,        1,   0, 8'h10, 1,   8'h00,            dat(8'h00));
    add_vec(0, 8'h00, 1, 0, 32'h0,        1,   1, 8'h10, 1,   8'h04,            dat(8'h04));
    add_vec(0, 8'h00, 0, 0, 32'h0,        1,   1, 8'h14, 1,   8'h08,            dat(8'h08));
    add_vec(0, 8'h00, 0, 1, dat(8'h10),   1,   1, 8'h14, 1,   8'h0C,            dat(8'h0C));
    add_vec(0, 8'h00, 0, 0, 32'h0,        0,   1, 8'h14, 1,   8'h10,            dat(8'h10));
    add_vec(0, 8'h00, 1, 0, 32'h0,        1,   1, 8'h14, 1,   8'h10,            dat(8'h10));
    add_vec(0, 8'h00, 1, 0, 32'h0,        1,   1, 8'h18, 0,   8'h00,            32'h0);
    add_vec(0, 8'h00, 1, 0, 32'h0,        1,   1, 8'h1C, 0,   8'h00,            32'h0);
    // redirect to 0x40 with three outstanding
    add_vec(1, 8'h40, 1, 0, 32'h0,        1,   0, 8'h20, 0,   8'h00,            32'h0);
    add_vec(0, 8'h00, 0, 1, dat(8'h14),   1,   1, 8'h40, 0,   8'h00,            32'h0);
    add_vec(0, 8'h00, 1, 1, dat(8'h18),   1,   1, 8'h40, 0,   8'h00,            32'h0);
    add_vec(0, 8'h00, 0, 1, dat(8'h1C),   1,   1, 8'h44, 0,   8'h00,            32'h0);
    add_vec(0, 8'h00, 0, 1, dat(8'h40),   0,   1, 8'h44, BYP, BYP ? 8'h40 : 8'h00, BYP ? dat(8'h40) : 32'h0);
    add_vec(0, 8'h00, 0, 0, 32'h0,        0,   1, 8'h44, 1,   8'h40,            dat(8'h40));
    // unaligned redirect, handshake on the same cycle is ignored
    add_vec(1, 8'h43, 0, 0, 32'h0,        1,   0, 8'h44, 1,   8'h40,            dat(8'h40));
    add_vec(0, 8'h00, 1, 0, 32'h0,        0,   1, 8'h40, 0,   8'h00,            32'h0);
    add_vec(0, 8'h00, 0, 1, 32'hB0000040, 0,   1, 8'h44, BYP, BYP ? 8'h40 : 8'h00, BYP ? 32'hB0000040 : 32'h0);
    add_vec(0, 8'h00, 1, 0, 32'h0,        0,   1, 8'h44, 1,   8'h40,            32'hB0000040);
    add_vec(0, 8'h00, 1, 0, 32'h0,        0,   1, 8'h48, 1,   8'h40,            32'hB0000040);
    // redirect coincident with a live response and an output handshake
    add_vec(1, 8'hF8, 1, 1, dat(8'h44),   1,   0, 8'h4C, 1,   8'h40,            32'hB0000040);
    add_vec(0, 8'h00, 0, 1, dat(8'h48),   0,   1, 8'hF8, 0,   8'h00,            32'h0);
    // address wrap 0xF8 -> 0xFC -> 0x00
    add_vec(0, 8'h00, 1, 0, 32'h0,        0,   1, 8'hF8, 0,   8'h00,            32'h0);
    add_vec(0, 8'h00, 1, 0, 32'h0,        0,   1, 8'hFC, 0,   8'h00,            32'h0);
    add_vec(0, 8'h00, 1, 0, 32'h0,        0,   1, 8'h00, 0,   8'h00,            32'h0);
    add_vec(0, 8'h00, 0, 1, dat(8'hF8),   0,   1, 8'h04, BYP, BYP ? 8'hF8 : 8'h00, BYP ? dat(8'hF8) : 32'h0);
    add_vec(0, 8'h00, 0, 1, dat(8'hFC),   1,   1, 8'h04, 1,   8'hF8,            dat(8'hF8));
    add_vec(0, 8'h00, 0, 1, dat(8'h00),   1,   1, 8'h04, 1,   8'hFC,            dat(8'hFC));
    add_vec(0, 8'h00, 0, 0, 32'h0,        1,   1, 8'h04, 1,   8'h00,            dat(8'h00));
    add_vec(0, 8'h00, 0, 0, 32'h0,        1,   1, 8'h04, 0,   8'h00,            32'h0);
    // empty-queue latency: 0 cycles with bypass, 1 cycle without
    add_vec(1, 8'h00, 0, 0, 32'h0,        0,   0, 8'h04, 0,   8'h00,            32'h0);
    add_vec(0, 8'h00, 1, 0, 32'h0,        0,   1, 8'h00, 0,   8'h00,            32'h0);
    add_vec(0, 8'h00, 0, 1, 32'h00500093, 1,   1, 8'h04, BYP, 8'h00,            BYP ? 32'h00500093 : 32'h0);
    add_vec(0, 8'h00, 0, 0, 32'h0,        1,   1, 8'h04, !BYP, 8'h00,           BYP ? 32'h0 : 32'h00500093);
    add_vec(0, 8'h00, 0, 0, 32'h0,        1,   1, 8'h04, 0,   8'h00,            32'h0);

    repeat (2) @(posedge clk);
    #1;
    check_output("reset_state", 0, 8'h00, 0, 8'h00, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      @(negedge clk);
      check_output($sformatf("vec%0d", i), vecs[i].qv, vecs[i].qa, vecs[i].ov,
                   vecs[i].opc, vecs[i].oin);
      @(posedge clk);
      #1;
    end

    // reset asserted mid-operation with two fetches in flight
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    out_ready      = 1'b0;
    imem_req_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    imem_req_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_reset", 0, 8'h00, 0, 8'h00, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    imem_req_ready = 1'b1;
    @(negedge clk);
    check_output("post_reset_fetch0", 1, 8'h00, 0, 8'h00, 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_output("post_reset_fetch1", 1, 8'h04, 0, 8'h00, 32'h0);
    @(posedge clk);
    #1;
    imem_req_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Consumer end of the next-PC path. Owns the architectural PC register, fetches from instruction memory over a valid/ready request plus in-order response interface, and buffers fetched words in a small queue.
- Delivers {pc, instr} pairs to decode over a valid/ready handshake.
- A redirect (taken branch/jump target from the PC-select logic) flushes the queue and drops in-flight responses.

Parameters:
- ADDRESS_WIDTH, 8, PC / instruction-memory byte-address width.
- DATA_WIDTH, 32, instruction word width.
- DEPTH, 4, queue entries; also the cap on in-flight plus buffered fetches; power of two, at least 2.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- redirect_valid  in  1  redirect request this cycle.
- redirect_pc  in  ADDRESS_WIDTH  new fetch address.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  ADDRESS_WIDTH  fetch byte address.
- imem_rsp_valid  in  1  response word valid; responses return in request order, at least 1 cycle after acceptance.
- imem_rsp_data  in  DATA_WIDTH  fetched instruction.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode accepts the head.
- out_pc  out  ADDRESS_WIDTH  PC of the head instruction.
- out_instr  out  DATA_WIDTH  head instruction.

Behaviour:
- **Reset (async assert, sync deassert by clk):**
  - fetch_pc = RESET_PC; queue empty; live_cnt = 0; drop_cnt = 0.
  - imem_req_valid = 0; out_valid = 0; out_pc = 0; out_instr = 0.
  - Reset mid-operation discards all in-flight state. Memory responses still arriving after reset are the system's responsibility; memory is reset together with this block.
- **Request issue:**
  - imem_req_valid = !redirect_valid && (live_cnt + drop_cnt + count < DEPTH).
  - imem_req_addr = fetch_pc.
  - On accept (valid && ready): fetch_pc += 4, modulo 2^ADDRESS_WIDTH (0xFC → 0x00); live_cnt++.
  - imem_req_addr must hold stable while valid && !ready.
- **Response handling:**
  - If drop_cnt > 0: discard the response, drop_cnt--.
  - Otherwise: push {pc tag, data}, live_cnt--.
  - The PC tag comes from a pending-PC FIFO (depth DEPTH) written at request accept.
  - Overflow cannot occur by construction. Bench asserts no push when full.
- **Output:** out_valid = !empty. A pop happens on out_valid && out_ready. Push and pop in the same cycle are legal when non-empty.
- **Redirect (redirect_valid = 1):**
  - The cycle's imem request is suppressed. The output handshake is ignored (no pop counted); the queue is flushed at the edge.
  - fetch_pc ← {redirect_pc[AW-1:2], 2'b00}.
  - drop_cnt ← drop_cnt + live_cnt − (live response arriving this cycle ? 1 : 0). The response arriving that cycle is itself discarded.
  - live_cnt ← 0. The pending-PC FIFO is flushed.
  - First fetch from the new PC is issued the following cycle.
  - Back-to-back redirects: the last one wins; drop_cnt accumulates.
- **Latency:** redirect at cycle N → imem_req_valid at N+1. Response accepted at cycle M → out_valid at M+1 (registered queue).
- **Width rule:** counters are clog2(DEPTH)+1 bits and never exceed DEPTH.

Optional Feature:
- Macro FETCH_BYPASS_EN.
- **Defined:** when the queue is empty, a live response arrives, and redirect_valid = 0, the response is driven combinationally to out_valid/out_pc/out_instr. If out_ready = 1 it is consumed with no push, giving 0-cycle latency. Otherwise it is pushed as normal.
- **Undefined:** no combinational imem_rsp → out path; minimum latency 1 cycle.

Decomposition:
- Package fetch_pkg:
  - PC_INCR = 4.
  - Typedef fetch_entry_t {pc, instr}.
  - Typedef fetch_cnt_t for the counters.
- Sub-module fetch_fifo: parameterised synchronous FIFO with flush, empty/full/count outputs. Instantiated twice: the instruction queue (fetch_entry_t) and the pending-PC FIFO.

Test Plan:
- **Reset:** after rst_n release with RESET_PC = 0x00, imem_req_addr sequence is 0x00, 0x04, 0x08, 0x0C. Issue stalls after 4 with no responses; out_valid = 0 throughout.
- **Backpressure:** out_ready = 0, memory 1-cycle latency → exactly 4 entries buffered, imem_req_valid = 0. out_ready = 1 → out_pc 0x00, 0x04, 0x08, 0x0C in order with the matching data.
- **Redirect with 3 outstanding:**
  - Stimulus: redirect_pc = 0x40.
  - The 3 stale responses are dropped and out_valid stays 0.
  - Next request address is 0x40; first delivered pc is 0x40.
- **Unaligned redirect and wrap:**
  - redirect_pc = 0x43 → fetch at 0x40.
  - redirect_pc = 0xF8 → addresses 0xF8, 0xFC, 0x00.
- **Redirect coincident with response and output handshake:** the queue is empty the next cycle, drop_cnt reflects the same-cycle response, and no stale pc ever appears on out_pc.
- **FETCH_BYPASS_EN:**
  - Queue empty, out_ready = 1, response 0x00500093 arrives → out_valid in the same cycle with pc = 0x00.
  - Without the macro, out_valid rises one cycle later.
